// File: rtl/photocell_conditioner_pkg.sv
// Shared photocell channel encodings and event levels, also used by the
// downstream person counter.
package photocell_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_CONF_BLK = 2'b01,
    ST_BLOCKED  = 2'b10,
    ST_CONF_CLR = 2'b11
  } chan_state_t;

  localparam logic PHOTO_EVENT = 1'b0;
  localparam logic PHOTO_IDLE  = 1'b1;

endpackage

// File: rtl/photocell_conditioner_channel.sv
// One photocell: 2-flop synchroniser, debounce FSM, stuck-beam detector and
// registered active-low event pulse.
module photocell_conditioner_channel
  import photocell_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEBOUNCE_W      = 3,
  parameter int STUCK_CYCLES    = 1000,
  parameter int STUCK_W         = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic photocell,
  output logic stuck
);

  localparam logic [DEBOUNCE_W-1:0] DEB_LAST  = DEBOUNCE_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DEBOUNCE_W-1:0] DEB_ONE   = DEBOUNCE_W'(1);
  localparam logic [STUCK_W-1:0]    STUCK_MAX = STUCK_W'(STUCK_CYCLES);
  localparam logic [STUCK_W-1:0]    STUCK_SET = STUCK_W'(STUCK_CYCLES - 1);

  logic                  sync1_reg;
  logic                  s_reg;
  chan_state_t           state_reg;
  logic [DEBOUNCE_W-1:0] cnt_reg;
  logic [STUCK_W-1:0]    stuck_cnt_reg;
  logic                  pulse_reg;
  logic                  stuck_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg     <= 1'b0;
      s_reg         <= 1'b0;
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      stuck_cnt_reg <= '0;
      pulse_reg     <= PHOTO_IDLE;
      stuck_reg     <= 1'b0;
    end else begin
      sync1_reg <= raw;
      s_reg     <= sync1_reg;
      pulse_reg <= PHOTO_IDLE;
      case (state_reg)
        ST_IDLE: begin
          if (s_reg) begin
            state_reg <= ST_CONF_BLK;
            cnt_reg   <= DEB_ONE;
          end
        end
        ST_CONF_BLK: begin
          if (!s_reg) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            state_reg <= ST_BLOCKED;
            cnt_reg   <= '0;
            pulse_reg <= PHOTO_EVENT;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_BLOCKED: begin
          // Flag rises on the same edge the counter reaches STUCK_CYCLES.
          if (stuck_cnt_reg != STUCK_MAX) stuck_cnt_reg <= stuck_cnt_reg + 1'b1;
          if (stuck_cnt_reg >= STUCK_SET) stuck_reg <= 1'b1;
          if (!s_reg) begin
            state_reg <= ST_CONF_CLR;
            cnt_reg   <= DEB_ONE;
          end
        end
        ST_CONF_CLR: begin
          if (s_reg) begin
            state_reg <= ST_BLOCKED;
            cnt_reg   <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            stuck_cnt_reg <= '0;
            stuck_reg     <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign photocell = pulse_reg;
  assign stuck     = stuck_reg;

endmodule

// File: rtl/photocell_conditioner.sv
// Queue-counter front end: two independent photocell channels
// (index 0 = back/entrance, index 1 = front/exit).
module photocell_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DEBOUNCE_W      = 3,
  parameter int STUCK_CYCLES    = 1000,
  parameter int STUCK_W         = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic front_raw,
  input  logic back_raw,
  output logic front_photocell,
  output logic back_photocell,
  output logic front_stuck,
  output logic back_stuck
);

  logic [1:0] raw_vec;
  logic [1:0] pulse_vec;
  logic [1:0] stuck_vec;

  assign raw_vec = {front_raw, back_raw};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      photocell_conditioner_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .DEBOUNCE_W     (DEBOUNCE_W),
        .STUCK_CYCLES   (STUCK_CYCLES),
        .STUCK_W        (STUCK_W)
      ) u_chan (
        .clk      (clk),
        .reset    (reset),
        .raw      (raw_vec[gi]),
        .photocell(pulse_vec[gi]),
        .stuck    (stuck_vec[gi])
      );
    end
  endgenerate

  assign back_photocell  = pulse_vec[0];
  assign front_photocell = pulse_vec[1];
  assign back_stuck      = stuck_vec[0];
  assign front_stuck     = stuck_vec[1];

endmodule

// File: tb/tb_photocell_conditioner.sv
// Directed bench for photocell_conditioner with DEBOUNCE_CYCLES=4, STUCK_CYCLES=20.
module tb_photocell_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic front_raw;
  logic back_raw;
  logic front_photocell;
  logic back_photocell;
  logic front_stuck;
  logic back_stuck;

  int checks = 0;
  int errors = 0;
  int step_no = 0;

  always #5 clk = ~clk;

  photocell_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .DEBOUNCE_W     (3),
    .STUCK_CYCLES   (20),
    .STUCK_W        (10)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .front_raw      (front_raw),
    .back_raw       (back_raw),
    .front_photocell(front_photocell),
    .back_photocell (back_photocell),
    .front_stuck    (front_stuck),
    .back_stuck     (back_stuck)
  );

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%b expected=%b", tag, step_no, obs, exp);
    end
  endtask

  // Advance one edge, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    step_no++;
  endtask

  // Run n edges; j counts from the edge that first samples the current inputs.
  // Back/front pulse expected low only at j==eb / j==ef; back_stuck expected
  // high for s_on <= j < s_off; front_stuck expected low throughout.
  task automatic run_window(input string tag, input int n, input int eb, input int ef,
                            input int s_on, input int s_off);
    for (int j = 0; j < n; j++) begin
      step();
      $display("%s j=%0d back=%b front=%b bstuck=%b fstuck=%b", tag, j,
               back_photocell, front_photocell, back_stuck, front_stuck);
      check({tag, "_back"},   back_photocell,  (j == eb) ? 1'b0 : 1'b1);
      check({tag, "_front"},  front_photocell, (j == ef) ? 1'b0 : 1'b1);
      check({tag, "_bstuck"}, back_stuck,      (j >= s_on && j < s_off) ? 1'b1 : 1'b0);
      check({tag, "_fstuck"}, front_stuck,     1'b0);
    end
  endtask

  localparam int NEVER = 100000;

  initial begin
    reset     = 1'b1;
    front_raw = 1'b0;
    back_raw  = 1'b0;
    run_window("reset", 3, -1, -1, NEVER, NEVER);
    reset = 1'b0;
    run_window("idle", 4, -1, -1, NEVER, NEVER);

    // 1: clean entry, held 30 cycles (stuck sets 20 edges after BLOCKED entry at j=5)
    back_raw = 1'b1;
    run_window("t1_hold", 30, 5, -1, 25, NEVER);
    back_raw = 1'b0;
    run_window("t1_rel", 10, -1, -1, 0, 5);

    // 2: 3-cycle glitch rejected, then a full-latency pulse proves return to IDLE
    back_raw = 1'b1;
    run_window("t2_glitch", 3, -1, -1, NEVER, NEVER);
    back_raw = 1'b0;
    run_window("t2_after", 10, -1, -1, NEVER, NEVER);
    back_raw = 1'b1;
    run_window("t2_fresh", 8, 5, -1, NEVER, NEVER);
    back_raw = 1'b0;
    run_window("t2_rel", 10, -1, -1, NEVER, NEVER);

    // 3: front chatters for 20 cycles, then held
    for (int i = 0; i < 20; i++) begin
      front_raw = (i % 2 == 0) ? 1'b1 : 1'b0;
      run_window("t3_chatter", 1, -1, -1, NEVER, NEVER);
    end
    front_raw = 1'b1;
    run_window("t3_hold", 10, -1, 5, NEVER, NEVER);
    front_raw = 1'b0;
    run_window("t3_rel", 10, -1, -1, NEVER, NEVER);

    // 4: simultaneous entry and exit
    front_raw = 1'b1;
    back_raw  = 1'b1;
    run_window("t4_both", 10, 5, 5, NEVER, NEVER);
    front_raw = 1'b0;
    back_raw  = 1'b0;
    run_window("t4_rel", 10, -1, -1, NEVER, NEVER);

    // 5: stuck beam, flag saturates, clears on release, no second pulse
    back_raw = 1'b1;
    run_window("t5_hold", 40, 5, -1, 25, NEVER);
    back_raw = 1'b0;
    run_window("t5_rel", 10, -1, -1, 0, 5);

    // 6: reset during CONF_BLK discards the event; fresh pulse afterwards
    back_raw = 1'b1;
    run_window("t6_pre", 4, -1, -1, NEVER, NEVER);
    reset = 1'b1;
    run_window("t6_reset", 2, -1, -1, NEVER, NEVER);
    reset = 1'b0;
    run_window("t6_fresh", 10, 5, -1, NEVER, NEVER);
    back_raw = 1'b0;
    run_window("t6_rel", 10, -1, -1, NEVER, NEVER);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
